// File: rtl/bram_ip_pkg.sv
// bram_ip shared constants and FSM state encoding.
// Imported by the line-buffer top and its memory.
package bram_ip_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;
  localparam int N_PIX  = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one sync write port, one sync read-first read port.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (1-cycle).
module bram_sdp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Read and write in one block: the read sees the pre-write content.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_ip.sv
// Row line buffer: bursts 28 parallel pixels into RAM, serves byte reads.
// Ports: clk, rst, load_en, DI (unused), ADDR_IP, DPL_0..27, rescale, D_OUT, load_done.
module bram_ip #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [DATA_W-1:0] DI,
  input  logic [ADDR_W-1:0] ADDR_IP,
  input  logic [DATA_W-1:0] DPL_0,
  input  logic [DATA_W-1:0] DPL_1,
  input  logic [DATA_W-1:0] DPL_2,
  input  logic [DATA_W-1:0] DPL_3,
  input  logic [DATA_W-1:0] DPL_4,
  input  logic [DATA_W-1:0] DPL_5,
  input  logic [DATA_W-1:0] DPL_6,
  input  logic [DATA_W-1:0] DPL_7,
  input  logic [DATA_W-1:0] DPL_8,
  input  logic [DATA_W-1:0] DPL_9,
  input  logic [DATA_W-1:0] DPL_10,
  input  logic [DATA_W-1:0] DPL_11,
  input  logic [DATA_W-1:0] DPL_12,
  input  logic [DATA_W-1:0] DPL_13,
  input  logic [DATA_W-1:0] DPL_14,
  input  logic [DATA_W-1:0] DPL_15,
  input  logic [DATA_W-1:0] DPL_16,
  input  logic [DATA_W-1:0] DPL_17,
  input  logic [DATA_W-1:0] DPL_18,
  input  logic [DATA_W-1:0] DPL_19,
  input  logic [DATA_W-1:0] DPL_20,
  input  logic [DATA_W-1:0] DPL_21,
  input  logic [DATA_W-1:0] DPL_22,
  input  logic [DATA_W-1:0] DPL_23,
  input  logic [DATA_W-1:0] DPL_24,
  input  logic [DATA_W-1:0] DPL_25,
  input  logic [DATA_W-1:0] DPL_26,
  input  logic [DATA_W-1:0] DPL_27,
  input  logic              rescale,
  output logic [DATA_W-1:0] D_OUT,
  output logic              load_done
);

  import bram_ip_pkg::*;

  logic [DATA_W-1:0] pix [N_PIX];

  assign pix = '{DPL_0,  DPL_1,  DPL_2,  DPL_3,
                 DPL_4,  DPL_5,  DPL_6,  DPL_7,
                 DPL_8,  DPL_9,  DPL_10, DPL_11,
                 DPL_12, DPL_13, DPL_14, DPL_15,
                 DPL_16, DPL_17, DPL_18, DPL_19,
                 DPL_20, DPL_21, DPL_22, DPL_23,
                 DPL_24, DPL_25, DPL_26, DPL_27};

  // DI is a reserved pin with no function.
  logic unused_di;
  assign unused_di = ^DI;

  state_e            state_q, state_d;
  logic [4:0]        k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              done_q, done_d;
  logic              rd_vld_q;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    done_d  = done_q;
    we      = 1'b0;
    waddr   = ADDR_IP;
    wdata   = pix[0];
    if (rescale) begin
      state_d = ST_IDLE;
      k_d     = 5'd0;
      done_d  = 1'b0;
    end else begin
      unique case (1'b1)
        state_q == ST_IDLE: begin
          if (load_en) begin
            we      = 1'b1;
            base_d  = ADDR_IP;
            k_d     = 5'd1;
            state_d = ST_LOAD;
          end
        end
        state_q == ST_LOAD: begin
          we    = 1'b1;
          // ADDR_W-bit sum wraps at the top of memory.
          waddr = base_q + ADDR_W'(k_q);
          wdata = pix[k_q];
          k_d   = k_q + 5'd1;
          if (k_q == 5'(N_PIX - 1)) begin
            k_d     = 5'd0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
        state_q == ST_DONE: begin
          if (!load_en) begin
            done_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          k_d     = 5'd0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= 5'd0;
      base_q   <= '0;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      base_q   <= base_d;
      done_q   <= done_d;
      rd_vld_q <= 1'b1;
    end
  end

  // RAM has no reset; the valid flag forces D_OUT to 0 after reset.
  bram_sdp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (we & ~rst),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (ADDR_IP),
    .rdata_o (rdata)
  );

  assign D_OUT     = rd_vld_q ? rdata : '0;
  assign load_done = done_q;

endmodule

// File: tb/tb_bram_ip.sv
// Self-checking bench for bram_ip against a row-level memory model.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_bram_ip;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [7:0]  DI;
  logic [10:0] ADDR_IP;
  logic [7:0]  dpl [28];
  logic        rescale;
  logic [7:0]  D_OUT;
  logic        load_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m   [2048];
  bit         known_m [2048];

  always #5 clk = ~clk;

  bram_ip dut (
    .clk(clk), .rst(rst), .load_en(load_en), .DI(DI),
    .ADDR_IP(ADDR_IP),
    .DPL_0(dpl[0]),   .DPL_1(dpl[1]),   .DPL_2(dpl[2]),
    .DPL_3(dpl[3]),   .DPL_4(dpl[4]),   .DPL_5(dpl[5]),
    .DPL_6(dpl[6]),   .DPL_7(dpl[7]),   .DPL_8(dpl[8]),
    .DPL_9(dpl[9]),   .DPL_10(dpl[10]), .DPL_11(dpl[11]),
    .DPL_12(dpl[12]), .DPL_13(dpl[13]), .DPL_14(dpl[14]),
    .DPL_15(dpl[15]), .DPL_16(dpl[16]), .DPL_17(dpl[17]),
    .DPL_18(dpl[18]), .DPL_19(dpl[19]), .DPL_20(dpl[20]),
    .DPL_21(dpl[21]), .DPL_22(dpl[22]), .DPL_23(dpl[23]),
    .DPL_24(dpl[24]), .DPL_25(dpl[25]), .DPL_26(dpl[26]),
    .DPL_27(dpl[27]),
    .rescale(rescale), .D_OUT(D_OUT), .load_done(load_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    DI = 8'($urandom);
  endtask

  // Model: the first n pixels of the row land at base+k mod 2048.
  task automatic model_row(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      mem_m[(base + k) % 2048]   = dpl[k];
      known_m[(base + k) % 2048] = 1'b1;
    end
  endtask

  task automatic set_row_rand();
    for (int k = 0; k < 28; k++) dpl[k] = 8'($urandom);
  endtask

  // Full handshake load; checks 28-edge latency and load_done fall.
  task automatic do_load(input int base, input string tag);
    int edges;
    ADDR_IP = 11'(base);
    load_en = 1'b1;
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!load_done && edges < 40);
    checks++;
    if (edges !== 28) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, want 28", tag, edges);
    end
    model_row(base, 28);
    tick();
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_hold: got %b want 1", tag, load_done);
    end
    load_en = 1'b0;
    tick();
    checks++;
    if (load_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_fall: got %b want 0", tag, load_done);
    end
  endtask

  task automatic read_chk(input int addr, input string tag);
    ADDR_IP = 11'(addr);
    tick();
    if (known_m[addr]) begin
      checks++;
      if (D_OUT !== mem_m[addr]) begin
        errors++;
        $display("FAIL %s read[%0d]: got %h want %h",
                 tag, addr, D_OUT, mem_m[addr]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load_en = 1'b0; rescale = 1'b0;
    ADDR_IP = '0; DI = '0;
    for (int k = 0; k < 28; k++) dpl[k] = '0;
    tick();
    tick();
    checks++;
    if (D_OUT !== 8'h00 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got D_OUT=%h done=%b want 00/0",
               D_OUT, load_done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    for (int k = 0; k < 28; k++) dpl[k] = 8'(k + 1);
    do_load(10, "basic");
    for (int a = 10; a < 38; a++) begin
      ADDR_IP = 11'(a);
      tick();
      checks++;
      if (D_OUT !== 8'(a - 9)) begin
        errors++;
        $display("FAIL basic read[%0d]: got %h want %h",
                 a, D_OUT, 8'(a - 9));
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_v [3];
    int         adr   [3];
    for (int k = 0; k < 28; k++) dpl[k] = 8'(8'hA0 + k);
    do_load(2040, "wrap");
    adr = '{2047, 0, 19};
    exp_v = '{8'hA7, 8'hA8, 8'hBB};
    for (int i = 0; i < 3; i++) begin
      ADDR_IP = 11'(adr[i]);
      tick();
      checks++;
      if (D_OUT !== exp_v[i]) begin
        errors++;
        $display("FAIL wrap mem[%0d]: got %h want %h",
                 adr[i], D_OUT, exp_v[i]);
      end
    end
  endtask

  task automatic test_abort();
    for (int k = 0; k < 28; k++) dpl[k] = 8'(8'h55 + k);
    do_load(100, "abort_pre");
    for (int k = 0; k < 28; k++) dpl[k] = 8'(k + 1);
    ADDR_IP = 11'd100;
    load_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    load_en = 1'b0;
    rescale = 1'b1;
    tick();
    rescale = 1'b0;
    model_row(100, 10);
    checks++;
    if (load_done !== 1'b0) begin
      errors++;
      $display("FAIL abort done: got %b want 0", load_done);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (load_done !== 1'b0) begin
        errors++;
        $display("FAIL abort done_stay: got %b want 0", load_done);
      end
    end
    for (int a = 100; a <= 110; a++) read_chk(a, "abort");
    set_row_rand();
    do_load(100, "abort_fresh");
    for (int a = 100; a < 128; a++) read_chk(a, "abort_fresh");
  endtask

  task automatic test_priority();
    int edges;
    set_row_rand();
    do_load(300, "prio_pre");
    set_row_rand();
    ADDR_IP = 11'd300;
    load_en = 1'b1;
    rescale = 1'b1;
    tick();
    rescale = 1'b0;
    ADDR_IP = 11'd320;
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!load_done && edges < 40);
    checks++;
    if (edges !== 28) begin
      errors++;
      $display("FAIL prio latency: got %0d edges, want 28", edges);
    end
    load_en = 1'b0;
    model_row(320, 28);
    tick();
    for (int a = 298; a < 350; a++) read_chk(a, "prio");
  endtask

  task automatic test_reset_mid();
    set_row_rand();
    do_load(600, "rstmid_pre");
    set_row_rand();
    ADDR_IP = 11'd600;
    load_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    load_en = 1'b0;
    tick();
    checks++;
    if (D_OUT !== 8'h00 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got D_OUT=%h done=%b want 00/0",
               D_OUT, load_done);
    end
    rst = 1'b0;
    model_row(600, 5);
    for (int a = 600; a < 628; a++) read_chk(a, "rst_mid");
  endtask

  task automatic test_rdw();
    logic [7:0] old_v;
    set_row_rand();
    do_load(800, "rdw_pre");
    set_row_rand();
    load_en = 1'b1;
    for (int k = 0; k < 28; k++) begin
      ADDR_IP = 11'(800 + k);
      old_v = mem_m[800 + k];
      tick();
      checks++;
      if (D_OUT !== old_v) begin
        errors++;
        $display("FAIL rdw[%0d]: got %h want old %h",
                 800 + k, D_OUT, old_v);
      end
      mem_m[800 + k] = dpl[k];
    end
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL rdw done: got %b want 1", load_done);
    end
    load_en = 1'b0;
    tick();
    for (int a = 800; a < 828; a++) read_chk(a, "rdw_new");
  endtask

  task automatic test_random();
    int base;
    for (int n = 0; n < 6; n++) begin
      set_row_rand();
      base = int'($urandom_range(0, 2047));
      do_load(base, "rand");
      for (int i = 0; i < 28; i++)
        read_chk((base + int'($urandom_range(0, 27))) % 2048, "rand");
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) known_m[a] = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_abort();
    test_priority();
    test_reset_mid();
    test_rdw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_ip.md
# bram_ip

Input-image line buffer for the NN accelerator. It bursts one 28-pixel row, presented in parallel on `DPL_0..DPL_27`, into an on-chip 2048 x 8 memory at consecutive addresses starting from a caller-supplied base. It then serves single-byte reads to downstream compute through a registered output. It sits between the pixel-row source and the first neural-network layer.

## Interface
- `DATA_W`, default 8: pixel / memory word width.
- `ADDR_W`, default 11: address width; memory depth is 2^ADDR_W = 2048.
- Row length is fixed at 28 (local constant `N_PIX`). It is not a parameter, because the port list is fixed.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `load_en`  in  1: level request to load the current row.
- `DI`  in  8: reserved. It is ignored and must not affect memory or outputs.
- `ADDR_IP`  in  11: load base address (sampled at load start) and read address (sampled every cycle).
- `DPL_0` .. `DPL_27`  in  8 each: row pixels; `DPL_k` is written to `base+k`.
- `rescale`  in  1: one-cycle re-arm/abort pulse.
- `D_OUT`  out  8: registered read data.
- `load_done`  out  1: registered flag, high once all 28 writes have completed.

## Operation
The FSM has three states: IDLE, LOAD and DONE. It uses a 5-bit index counter `k` and an 11-bit latched base address `base`.

- **IDLE**
  - On an edge with `load_en`=1: set `base`=`ADDR_IP`, write `DPL_0` to `mem[ADDR_IP]`, set `k`=1, go to LOAD.
- **LOAD**
  - Each edge writes `DPL_k` to `mem[(base+k) mod 2048]`, then increments `k`.
  - The edge that writes `k`=27 also sets `load_done`=1 and goes to DONE.
  - `load_en` is ignored during LOAD. The burst always completes unless `rescale` or `rst` intervenes.
  - `DPL_*` are sampled on their own write edge. The source holds them stable for the whole burst.
- **DONE**
  - Hold `load_done`=1 while `load_en`=1.
  - On the first edge with `load_en`=0: clear `load_done` and go to IDLE.
- **`rescale`=1 (any state)**
  - Next state is IDLE, `k`=0, `load_done`=0, and no write occurs that edge.
  - Memory contents are kept, so a partially written row remains in memory.
- **Priority:** `rst` > `rescale` > `load_en`.
  - If `rescale` and `load_en` are both high, the FSM stays in IDLE that cycle.
  - A new load starts on the next edge where `load_en`=1 and `rescale`=0.
- **Read path:**
  - Every edge, in every state: `D_OUT` <= `mem[ADDR_IP]`.
  - Read-first: if the read address equals the address being written on the same edge, `D_OUT` returns the old content.
- **Address arithmetic:** `base+k` wraps modulo 2048. For example, base 2040 writes to 2040..2047 and then 0..19.

## Timing
- **Reset values:** `D_OUT`=0, `load_done`=0, state=IDLE, `k`=0, `base`=0. Memory is not cleared.
- **Load latency:** 28 edges from the first edge sampling `load_en`=1. `load_done` is visible after the 28th edge, i.e. 27 cycles after entry to LOAD.
- **Read latency:** 1 cycle; `D_OUT` is valid after the edge following an `ADDR_IP` change.
- **Handshake:**
  - Hold `load_en` until `load_done` is seen, then drop it.
  - `load_done` falls one edge after `load_en` falls.
- **Reset mid-burst:** the burst aborts immediately and writes already performed persist.

## Structure
- **Shared package `bram_ip_pkg`:**
  - Constants `DATA_W`=8, `ADDR_W`=11, `DEPTH`=2048, `N_PIX`=28.
  - State encoding: IDLE=0, LOAD=1, DONE=2.
- **Sub-module `bram_sdp`:** simple dual-port memory, 2048 x 8, with one synchronous write port, one synchronous read-first read port, and no reset. It is inferable as block RAM.
- **Top level:** the FSM, counter, base latch, and a 28:1 pixel mux on `k`.

## Test plan
- **Basic load and read:**
  - Stimulus: reset 2 cycles; `DPL_k`=k+1; `ADDR_IP`=10; `load_en`=1 until `load_done`, then 0; read addresses 10..37.
  - Required: `D_OUT` = 1..28 in order; `load_done` rises exactly 28 edges after `load_en`; `load_done` falls one edge after `load_en` drops.
- **Address wrap:**
  - Stimulus: base 2040, `DPL_k`=0xA0+k.
  - Required: `mem[2047]`=0xA7, `mem[0]`=0xA8, `mem[19]`=0xBB.
- **Abort:**
  - Stimulus: `rescale` pulse after 10 writes at base 100 with `DPL_k`=k+1.
  - Required: addresses 100..109 = 1..10; 110 keeps its old value; `load_done` stays 0; a fresh load afterwards completes normally.
- **Priority:**
  - Stimulus: `rescale` and `load_en` high on the same edge.
  - Required: no write that edge; the load starts on the next edge with base sampled there.
- **Reset mid-load:**
  - Stimulus: `rst` at write 5.
  - Required: `D_OUT`=0, `load_done`=0 next cycle; writes 0..4 persist.
- **Read-during-write and `DI` isolation:**
  - Stimulus: `ADDR_IP` = an address being written on the same edge; toggle `DI` throughout.
  - Required: the old value is returned on that edge; `DI` has no effect on memory or outputs.
